// File: rtl/btn_debounce_pulse_if.sv
// Button bundle between the board pins and the game logic.
// master: side that drives the raw pins; slave: the conditioner.
interface btn_debounce_pulse_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output any_press
    );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, per-channel stability-counter
// debounce, one-cycle press/release strobes and an optional auto-repeat strobe.
// All outputs are registered.
module btn_debounce_pulse #(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 650_000,
    parameter int unsigned REPEAT_DELAY    = 26_000_000,
    parameter int unsigned REPEAT_PERIOD   = 6_500_000
) (
    input logic                 clk,
    input logic                 rst_n,
    btn_debounce_pulse_if.slave bus
);
    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RcntW  = $clog2(RepMax) + 1;

    localparam logic [CntW-1:0]  CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
    // Guarded so a disabled repeat (delay 0) does not underflow.
    localparam logic [RcntW-1:0] DelayLast  = RcntW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RcntW-1:0] PeriodLast = RcntW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_d_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
    logic [N_BTN-1:0] repeat_v;
    logic             any_press_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        (* ASYNC_REG = "TRUE" *) logic s1_q;
        (* ASYNC_REG = "TRUE" *) logic s2_q;
        logic            stable_q, stable_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            press_q, press_d;
        logic            release_q, release_d;

        // Debounce next state: count while the synchronised input disagrees,
        // accept on the last count, clear whenever it agrees again.
        always_comb begin
            stable_d  = stable_q;
            cnt_d     = '0;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s2_q != stable_q) begin
                if (cnt_q == CntLast) begin
                    stable_d  = s2_q;
                    press_d   = s2_q;
                    release_d = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        // Synchroniser, debounce state and registered strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                stable_q  <= 1'b0;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1_q      <= bus.btn_raw[i];
                s2_q      <= s1_q;
                stable_q  <= stable_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign level_v[i]   = stable_q;
        assign press_d_v[i] = press_d;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;

        if (REPEAT_DELAY == 0) begin : g_no_rep
            assign repeat_v[i] = 1'b0;
        end else begin : g_rep
            rep_state_e       st_q;
            logic [RcntW-1:0] rcnt_q;
            logic             rep_q;

            // Auto-repeat FSM; an accepted release wins over any strobe due this cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_q   <= StIdle;
                    rcnt_q <= '0;
                    rep_q  <= 1'b0;
                end else begin
                    rep_q <= 1'b0;
                    if (release_d) begin
                        st_q   <= StIdle;
                        rcnt_q <= '0;
                    end else begin
                        unique case (st_q)
                            StIdle: begin
                                if (press_d) begin
                                    st_q   <= StDelay;
                                    rcnt_q <= '0;
                                end
                            end
                            StDelay: begin
                                if (rcnt_q == DelayLast) begin
                                    rep_q  <= 1'b1;
                                    rcnt_q <= '0;
                                    st_q   <= StRepeat;
                                end else begin
                                    rcnt_q <= rcnt_q + RcntW'(1);
                                end
                            end
                            StRepeat: begin
                                if (rcnt_q == PeriodLast) begin
                                    rep_q  <= 1'b1;
                                    rcnt_q <= '0;
                                end else begin
                                    rcnt_q <= rcnt_q + RcntW'(1);
                                end
                            end
                            default: begin
                                st_q   <= StIdle;
                                rcnt_q <= '0;
                            end
                        endcase
                    end
                end
            end

            assign repeat_v[i] = rep_q;
        end
    end

    // any_press registered from the same next-state as btn_press so both align.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_d_v;
        end
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_repeat  = repeat_v;
    assign bus.any_press   = any_press_q;
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Inputs change 1 time unit after a rising edge, so the next
// rising edge is E1; outputs are sampled 1 time unit after each edge.
module tb_btn_debounce_pulse;
    localparam int unsigned NB = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    btn_debounce_pulse_if #(.N_BTN(NB)) bus ();

    btn_debounce_pulse #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.btn_raw = 5'b11111;
        tick(3);
        n_cmp++; if (bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL rst_level: got %b want %b", bus.btn_level, 5'b0); end
        n_cmp++; if (bus.btn_press !== 5'b0) begin n_err++;
            $display("FAIL rst_press: got %b want %b", bus.btn_press, 5'b0); end
        n_cmp++; if (bus.btn_release !== 5'b0) begin n_err++;
            $display("FAIL rst_release: got %b want %b", bus.btn_release, 5'b0); end
        n_cmp++; if (bus.btn_repeat !== 5'b0) begin n_err++;
            $display("FAIL rst_repeat: got %b want %b", bus.btn_repeat, 5'b0); end
        n_cmp++; if (bus.any_press !== 1'b0) begin n_err++;
            $display("FAIL rst_any: got %b want 0", bus.any_press); end
        rst_n = 1'b1;
        tick(5);
        n_cmp++; if (bus.btn_press !== 5'b0 || bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL rst_early: press %b level %b want 0/0", bus.btn_press,
                     bus.btn_level); end
        tick(1);
        n_cmp++; if (bus.btn_press !== 5'b11111) begin n_err++;
            $display("FAIL rst_press_e6: got %b want %b", bus.btn_press, 5'b11111); end
        n_cmp++; if (bus.btn_level !== 5'b11111) begin n_err++;
            $display("FAIL rst_level_e6: got %b want %b", bus.btn_level, 5'b11111); end
        n_cmp++; if (bus.any_press !== 1'b1) begin n_err++;
            $display("FAIL rst_any_e6: got %b want 1", bus.any_press); end
        tick(1);
        n_cmp++; if (bus.btn_press !== 5'b0 || bus.any_press !== 1'b0) begin n_err++;
            $display("FAIL rst_press_e7: press %b any %b want 0/0", bus.btn_press,
                     bus.any_press); end
        bus.btn_raw = 5'b0;
        tick(5);
        n_cmp++; if (bus.btn_release !== 5'b0) begin n_err++;
            $display("FAIL rst_rel_early: got %b want %b", bus.btn_release, 5'b0); end
        tick(1);
        n_cmp++; if (bus.btn_release !== 5'b11111 || bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL rst_rel: release %b level %b want 11111/00000",
                     bus.btn_release, bus.btn_level); end
        tick(1);
        n_cmp++; if (bus.btn_release !== 5'b0) begin n_err++;
            $display("FAIL rst_rel_after: got %b want %b", bus.btn_release, 5'b0); end
    endtask

    task automatic test_single;
        bus.btn_raw = 5'b00001;
        tick(5);
        n_cmp++; if (bus.btn_press !== 5'b0) begin n_err++;
            $display("FAIL single_early: got %b want %b", bus.btn_press, 5'b0); end
        tick(1);
        n_cmp++; if (bus.btn_press !== 5'b00001 || bus.btn_level !== 5'b00001) begin n_err++;
            $display("FAIL single_press: press %b level %b want 00001/00001",
                     bus.btn_press, bus.btn_level); end
        tick(1);
        n_cmp++; if (bus.btn_press !== 5'b0 || bus.btn_level !== 5'b00001) begin n_err++;
            $display("FAIL single_hold: press %b level %b want 00000/00001",
                     bus.btn_press, bus.btn_level); end
        bus.btn_raw = 5'b0;
        tick(5);
        n_cmp++; if (bus.btn_release !== 5'b0) begin n_err++;
            $display("FAIL single_rel_early: got %b want %b", bus.btn_release, 5'b0); end
        tick(1);
        n_cmp++; if (bus.btn_release !== 5'b00001 || bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL single_rel: release %b level %b want 00001/00000",
                     bus.btn_release, bus.btn_level); end
        tick(1);
        n_cmp++; if (bus.btn_release !== 5'b0) begin n_err++;
            $display("FAIL single_rel_after: got %b want %b", bus.btn_release, 5'b0); end
    endtask

    task automatic test_bounce;
        logic [15:0] pat;
        pat = 16'b0000_0000_0111_0111;  // LSB first: 1,1,1,0,1,1,1,0...
        for (int k = 0; k < 16; k++) begin
            bus.btn_raw[2] = pat[k];
            tick(1);
            n_cmp++;
            if ({bus.btn_press[2], bus.btn_release[2], bus.btn_level[2]} !== 3'b000) begin
                n_err++;
                $display("FAIL bounce_k%0d: press/rel/level %b%b%b want 000", k,
                         bus.btn_press[2], bus.btn_release[2], bus.btn_level[2]);
            end
        end
    endtask

    task automatic test_repeat;
        logic [NB-1:0] exp_p;
        logic [NB-1:0] exp_r;
        bus.btn_raw = 5'b10000;
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            exp_p = (k == 6) ? 5'b10000 : 5'b0;
            exp_r = (k >= 26 && (k - 26) % 8 == 0) ? 5'b10000 : 5'b0;
            n_cmp++; if (bus.btn_press !== exp_p) begin n_err++;
                $display("FAIL rep_press_e%0d: got %b want %b", k, bus.btn_press, exp_p); end
            n_cmp++; if (bus.btn_repeat !== exp_r) begin n_err++;
                $display("FAIL rep_strobe_e%0d: got %b want %b", k, bus.btn_repeat, exp_r); end
        end
        // Release is accepted at E66, exactly when the next repeat would be due.
        bus.btn_raw = 5'b0;
        for (int k = 61; k <= 76; k++) begin
            tick(1);
            exp_p = (k == 66) ? 5'b10000 : 5'b0;
            n_cmp++; if (bus.btn_release !== exp_p) begin n_err++;
                $display("FAIL rep_rel_e%0d: got %b want %b", k, bus.btn_release, exp_p); end
            n_cmp++; if (bus.btn_repeat !== 5'b0) begin n_err++;
                $display("FAIL rep_after_e%0d: got %b want %b", k, bus.btn_repeat, 5'b0); end
        end
    endtask

    task automatic test_simultaneous;
        bus.btn_raw = 5'b01010;
        tick(5);
        n_cmp++; if (bus.any_press !== 1'b0 || bus.btn_press !== 5'b0) begin n_err++;
            $display("FAIL simul_early: any %b press %b want 0/00000", bus.any_press,
                     bus.btn_press); end
        tick(1);
        n_cmp++; if (bus.btn_press !== 5'b01010) begin n_err++;
            $display("FAIL simul_press: got %b want %b", bus.btn_press, 5'b01010); end
        n_cmp++; if (bus.any_press !== 1'b1) begin n_err++;
            $display("FAIL simul_any: got %b want 1", bus.any_press); end
        tick(1);
        n_cmp++; if (bus.any_press !== 1'b0 || bus.btn_press !== 5'b0) begin n_err++;
            $display("FAIL simul_after: any %b press %b want 0/00000", bus.any_press,
                     bus.btn_press); end
        bus.btn_raw = 5'b0;
        tick(6);
        n_cmp++; if (bus.btn_release !== 5'b01010) begin n_err++;
            $display("FAIL simul_rel: got %b want %b", bus.btn_release, 5'b01010); end
        tick(2);
    endtask

    task automatic test_reset_mid;
        logic [NB-1:0] exp_p;
        logic [NB-1:0] exp_r;
        bus.btn_raw = 5'b10000;
        tick(27);  // press at E6, first repeat at E26: now in the repeat phase
        n_cmp++; if (bus.btn_level !== 5'b10000) begin n_err++;
            $display("FAIL mid_pre_level: got %b want %b", bus.btn_level, 5'b10000); end
        bus.btn_raw = 5'b10001;
        tick(4);   // channel 0 debounce count is 2
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL mid_async_level: got %b want %b", bus.btn_level, 5'b0); end
        n_cmp++; if ({bus.btn_press, bus.btn_release, bus.btn_repeat, bus.any_press} !== 16'b0)
        begin n_err++;
            $display("FAIL mid_async_strobes: press %b rel %b rep %b any %b want 0",
                     bus.btn_press, bus.btn_release, bus.btn_repeat, bus.any_press); end
        tick(2);
        n_cmp++; if (bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL mid_hold_level: got %b want %b", bus.btn_level, 5'b0); end
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            exp_p = (k == 6) ? 5'b10001 : 5'b0;
            exp_r = (k == 26) ? 5'b10001 : 5'b0;
            n_cmp++; if (bus.btn_press !== exp_p) begin n_err++;
                $display("FAIL mid_press_e%0d: got %b want %b", k, bus.btn_press, exp_p); end
            n_cmp++; if (bus.btn_repeat !== exp_r) begin n_err++;
                $display("FAIL mid_rep_e%0d: got %b want %b", k, bus.btn_repeat, exp_r); end
        end
        n_cmp++; if (bus.btn_level !== 5'b10001) begin n_err++;
            $display("FAIL mid_post_level: got %b want %b", bus.btn_level, 5'b10001); end
        bus.btn_raw = 5'b0;
        tick(8);
        n_cmp++; if (bus.btn_level !== 5'b0) begin n_err++;
            $display("FAIL mid_final_level: got %b want %b", bus.btn_level, 5'b0); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.btn_raw = '0;
        #1;
        test_reset();
        test_single();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
